// File: rtl/sequence_gen_pkg.sv
// Shared constants for the serial sequence generator: default widths and FSM state encoding.
package sequence_gen_pkg;

    localparam int unsigned PAT_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned STATE_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sequence_generator_if.sv
// Request/config and serial-output bundle of the sequence generator.
interface sequence_generator_if
    import sequence_gen_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    localparam int unsigned LEN_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    logic               start;
    logic [PAT_W-1:0]   pattern;
    logic [LEN_W-1:0]   pat_len;
    logic [CNT_W-1:0]   repeat_cnt;
    logic [CNT_W-1:0]   gap;
    logic               out_stream;
    logic               out_valid;
    logic               busy;
    logic               done;
    logic [STATE_W-1:0] state;

    modport master (
        output start, pattern, pat_len, repeat_cnt, gap,
        input  out_stream, out_valid, busy, done, state
    );

    modport slave (
        input  start, pattern, pat_len, repeat_cnt, gap,
        output out_stream, out_valid, busy, done, state
    );

endinterface

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first shift register: keeps a captured copy for reloads and a registered serial bit.
module seq_shift_reg #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 3
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    output logic             bit_out,
    output logic             last_c
);

    logic [PAT_W-1:0] pat_cap_q;
    logic [LEN_W-1:0] len_cap_q;
    logic [PAT_W-1:0] sr_q;
    logic [LEN_W-1:0] idx_q;
    logic             bit_q;
    logic [PAT_W-1:0] load_al_c;
    logic [PAT_W-1:0] reload_al_c;

    // Left-align so bit pat_len sits in the MSB; bits above pat_len fall off.
    always_comb begin
        load_al_c   = pattern   << (LEN_W'(PAT_W - 1) - pat_len);
        reload_al_c = pat_cap_q << (LEN_W'(PAT_W - 1) - len_cap_q);
    end

    // The current bit is in bit_q; idx_q counts the bits still to follow it.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pat_cap_q <= '0;
            len_cap_q <= '0;
            sr_q      <= '0;
            idx_q     <= '0;
            bit_q     <= 1'b0;
        end else if (load) begin
            pat_cap_q <= pattern;
            len_cap_q <= pat_len;
            bit_q     <= load_al_c[PAT_W-1];
            sr_q      <= load_al_c << 1;
            idx_q     <= pat_len;
        end else if (reload) begin
            bit_q     <= reload_al_c[PAT_W-1];
            sr_q      <= reload_al_c << 1;
            idx_q     <= len_cap_q;
        end else if (shift) begin
            bit_q     <= sr_q[PAT_W-1];
            sr_q      <= sr_q << 1;
            idx_q     <= idx_q - LEN_W'(1);
        end else begin
            bit_q     <= 1'b0;
        end
    end

    assign bit_out = bit_q;
    assign last_c  = (idx_q == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern generator: repeats a captured pattern MSB-first with optional idle gaps.
module sequence_generator
    import sequence_gen_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    sequence_generator_if.slave  bus
);

    localparam int unsigned LEN_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] gap_cap_q, gap_cap_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic             load_c, reload_c, shift_c;
    logic             last_c;
    logic             bit_out;
    logic             out_valid_q, busy_q, done_q;

    seq_shift_reg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shift (
        .clk        (clk),
        .sync_reset (sync_reset),
        .load       (load_c),
        .reload     (reload_c),
        .shift      (shift_c),
        .pattern    (bus.pattern),
        .pat_len    (bus.pat_len),
        .bit_out    (bit_out),
        .last_c     (last_c)
    );

    // State, counters and status flags; status is derived from the next state so it lines up with the bit.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q     <= ST_IDLE;
            rep_q       <= '0;
            gap_cap_q   <= '0;
            gcnt_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_q       <= rep_d;
            gap_cap_q   <= gap_cap_d;
            gcnt_q      <= gcnt_d;
            out_valid_q <= (state_d == ST_SHIFT);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    // rep_q holds the passes still owed after the current one.
    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        gap_cap_d = gap_cap_q;
        gcnt_d    = gcnt_q;
        load_c    = 1'b0;
        reload_c  = 1'b0;
        shift_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load_c    = 1'b1;
                    rep_d     = bus.repeat_cnt;
                    gap_cap_d = bus.gap;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!last_c) begin
                    shift_c = 1'b1;
                end else if (rep_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    rep_d = rep_q - CNT_W'(1);
                    if (gap_cap_q != '0) begin
                        gcnt_d  = gap_cap_q - CNT_W'(1);
                        state_d = ST_GAP;
                    end else begin
                        reload_c = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gcnt_q == '0) begin
                    reload_c = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    gcnt_d = gcnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.out_stream = bit_out;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: per-cycle queue model of the output stream plus literal stream checks.
module tb_sequence_generator;
    import sequence_gen_pkg::*;

    localparam int unsigned PW = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic sync_reset;
    always #5 clk = ~clk;

    sequence_generator_if #(.PAT_W(PW), .CNT_W(CW)) bus ();

    sequence_generator #(.PAT_W(PW), .CNT_W(CW)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    typedef struct packed {
        logic       b;
        logic       v;
        logic       bz;
        logic       dn;
        logic [1:0] st;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          run_chk = 1'b0;
    logic [63:0] obs_bits, obs_valid;
    int          obs_n, done_n, done_at;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Expected cycle-by-cycle trace of one accepted request.
    function automatic void model_push(input logic [7:0] p, input int len, input int rc, input int g);
        for (int r = 0; r <= rc; r++) begin
            for (int b = len; b >= 0; b--) exp_q.push_back('{p[b], 1'b1, 1'b1, 1'b0, 2'(ST_SHIFT)});
            if (r < rc)
                for (int k = 0; k < g; k++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'(ST_GAP)});
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 2'(ST_DONE)});
    endfunction

    always @(negedge clk) begin : cmp
        exp_t e;
        if (run_chk) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            chk("out_stream", 64'(bus.out_stream), 64'(e.b));
            chk("out_valid",  64'(bus.out_valid),  64'(e.v));
            chk("busy",       64'(bus.busy),       64'(e.bz));
            chk("done",       64'(bus.done),       64'(e.dn));
            chk("state",      64'(bus.state),      64'(e.st));
            obs_bits  = {obs_bits[62:0], bus.out_stream};
            obs_valid = {obs_valid[62:0], bus.out_valid};
            if (bus.done === 1'b1) begin
                done_n++;
                done_at = obs_n;
            end
            obs_n++;
        end
    end

    task automatic clear_log();
        obs_bits = '0; obs_valid = '0; obs_n = 0; done_n = 0; done_at = -1;
    endtask

    task automatic set_cfg(input logic [7:0] p, input int l, input int rc, input int g);
        bus.pattern = p; bus.pat_len = 3'(l); bus.repeat_cnt = 4'(rc); bus.gap = 4'(g);
    endtask

    // One clock with start=s; the model accepts only when it believes the DUT is idle.
    task automatic step(input bit s);
        logic [7:0] p; int l, rc, g; bit acc;
        bus.start = s;
        p = bus.pattern; l = int'(bus.pat_len); rc = int'(bus.repeat_cnt); g = int'(bus.gap);
        acc = s && (exp_q.size() == 0) && !sync_reset;
        @(posedge clk); #1;
        if (acc) model_push(p, l, rc, g);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step(1'b0);
        chk(name, 64'(exp_q.size()), 64'd0);
        steps(2);
    endtask

    task automatic do_reset(input string name);
        sync_reset = 1'b1; bus.start = 1'b0;
        @(posedge clk); #1;
        sync_reset = 1'b0;
        exp_q.delete();
        chk({name, "_state"}, 64'(bus.state), 64'd0);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({name, "_busy"},  64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        sync_reset = 1'b1;
        bus.start  = 1'b0;
        set_cfg(8'h00, 0, 0, 0);
        clear_log();
        @(posedge clk); #1;
        run_chk = 1'b1;
        chk("rst_state", 64'(bus.state), 64'd0);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_done",  64'(bus.done),  64'd0);
        @(posedge clk); #1;
        sync_reset = 1'b0;
        steps(2);

        // Single pass, 4 bits
        set_cfg(8'b0000_1011, 3, 0, 0);
        clear_log(); step(1'b1); steps(7);
        chk("t1_bits",  obs_bits,  64'h58);
        chk("t1_valid", obs_valid, 64'h78);
        chk("t1_done_at", 64'(done_at), 64'd5);
        chk("t1_done_n",  64'(done_n),  64'd1);
        chk("t1_len", 64'(obs_n), 64'd8);
        drain("t1_drain");

        // Two passes with two gap cycles
        set_cfg(8'b0000_1011, 3, 1, 2);
        clear_log(); step(1'b1); steps(13);
        chk("t2_bits",  obs_bits,  64'h1658);
        chk("t2_valid", obs_valid, 64'h1E78);
        chk("t2_done_at", 64'(done_at), 64'd11);
        chk("t2_done_n",  64'(done_n),  64'd1);
        drain("t2_drain");

        // Back-to-back passes, no bubble
        set_cfg(8'hA5, 7, 1, 0);
        clear_log(); step(1'b1); steps(18);
        chk("t3_bits",  obs_bits,  64'h29694);
        chk("t3_valid", obs_valid, 64'h3FFFC);
        chk("t3_done_at", 64'(done_at), 64'd17);
        drain("t3_drain");

        // Re-pulsed start and mid-run input changes must not disturb the run
        set_cfg(8'b0000_1011, 3, 1, 2);
        clear_log();
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        set_cfg(8'hFF, 7, 3, 0);
        step(1'b1); steps(5); step(1'b1); step(1'b0); step(1'b0);
        chk("t4_bits",  obs_bits,  64'h1658);
        chk("t4_valid", obs_valid, 64'h1E78);
        chk("t4_done_n", 64'(done_n), 64'd1);
        drain("t4_drain");

        // Reset during the 3rd bit, then during a gap
        set_cfg(8'b0000_1011, 3, 1, 2);
        clear_log(); step(1'b1); steps(2);
        do_reset("t5a");
        steps(3);
        step(1'b1); steps(4);
        do_reset("t5b");
        steps(6);
        chk("t5_no_done", 64'(done_n), 64'd0);
        set_cfg(8'b0000_1011, 3, 0, 0);
        clear_log(); step(1'b1); steps(7);
        chk("t5_rerun_bits", obs_bits, 64'h58);
        drain("t5_drain");

        // Reset wins over start in the same cycle
        sync_reset = 1'b1; step(1'b1); sync_reset = 1'b0; exp_q.delete();
        chk("t6_state", 64'(bus.state), 64'd0);
        step(1'b0);
        chk("t6_busy", 64'(bus.busy), 64'd0);
        steps(2);

        // Maximum repeat count with a one-bit pattern
        set_cfg(8'h01, 0, 15, 0);
        clear_log(); step(1'b1); steps(18);
        chk("t7_bits",    obs_bits,  64'h3FFFC);
        chk("t7_done_at", 64'(done_at), 64'd17);
        chk("t7_done_n",  64'(done_n),  64'd1);
        drain("t7_drain");

        // pat_len=0 sends only pattern[0], upper bits ignored
        set_cfg(8'hFE, 0, 2, 1);
        clear_log(); step(1'b1); steps(8);
        chk("t8_bits",  obs_bits,  64'h0);
        chk("t8_valid", obs_valid, 64'h0A8);
        drain("t8_drain");

        // Further model-only patterns
        set_cfg(8'h5C, 5, 2, 3); step(1'b1); drain("t9_drain");
        set_cfg(8'h96, 6, 0, 0); step(1'b1); drain("t10_drain");
        set_cfg(8'h3C, 7, 3, 1); step(1'b1); drain("t11_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 The block SHALL have parameter PAT_W, default 8: maximum pattern length in bits.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the repeat and gap fields.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port sync_reset, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1: request to transmit; sampled only in IDLE.
REQ-006 The block SHALL have port pattern, input, PAT_W: bits to serialize.
REQ-007 The block SHALL have port pat_len, input, clog2(PAT_W): pattern length minus 1.
REQ-008 The block SHALL have port repeat_cnt, input, CNT_W: number of repetitions minus 1.
REQ-009 The block SHALL have port gap, input, CNT_W: idle cycles inserted between repetitions.
REQ-010 The block SHALL have port out_stream, output, 1: serial bit, suitable for a detector's in_stream.
REQ-011 The block SHALL have port out_valid, output, 1: high while out_stream carries a pattern bit.
REQ-012 The block SHALL have port busy, output, 1: high in SHIFT, GAP and DONE.
REQ-013 The block SHALL have port done, output, 1: one-cycle pulse after the final bit.
REQ-014 The block SHALL have port state, output, 2: current FSM state, for debug and monitoring.

Function
REQ-015 FSM states SHALL be encoded IDLE=0, SHIFT=1, GAP=2, DONE=3.
REQ-016 In IDLE with start=1 at edge N, the block SHALL capture pattern, pat_len, repeat_cnt and gap, and enter SHIFT; the first bit appears on out_stream in cycle N+1.
REQ-017 Changes to inputs after capture SHALL have no effect until the next accepted start.
REQ-018 In SHIFT, the block SHALL drive pattern[pat_len] down to pattern[0], one bit per cycle, MSB first, with out_valid=1; this is pat_len+1 cycles per repetition.
REQ-019 After the last bit of a repetition, the block SHALL act as follows:
- repetitions remaining and gap>0: enter GAP for exactly gap cycles;
- repetitions remaining and gap=0: restart SHIFT on the next cycle with no bubble;
- no repetitions remaining: enter DONE.
REQ-020 In GAP, the block SHALL hold out_stream=0 and out_valid=0, then return to SHIFT with the captured pattern reloaded.
REQ-021 The total number of repetitions SHALL be repeat_cnt+1; repeat_cnt=0 gives one pass, and the maximum 2^CNT_W passes is exact, with no counter wrap.
REQ-022 DONE SHALL last exactly one cycle with done=1, then the block SHALL return to IDLE; start asserted during DONE is ignored.
REQ-023 start asserted in SHIFT or GAP SHALL be ignored; it does not queue.
REQ-024 Outside SHIFT, out_stream SHALL be 0 and out_valid SHALL be 0.
REQ-025 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-026 With pat_len=0, the block SHALL transmit a single bit, pattern[0].

Reset
REQ-027 On sync_reset=1 at a rising edge, the block SHALL enter IDLE with out_stream=0, out_valid=0, busy=0, done=0 and state=0, in every state including mid-SHIFT and mid-GAP.
REQ-028 Reset SHALL take priority over start in the same cycle.
REQ-029 Captured registers and counters SHALL clear to 0 on reset.

Structure
REQ-030 Package sequence_gen_pkg SHALL hold:
- the state encoding constants;
- the PAT_W and CNT_W defaults.
REQ-031 A single sub-module, seq_shift_reg, SHALL implement the loadable MSB-first shift register with bit-index counter; the FSM, repetition counter and gap counter SHALL stay in the top module.

Verification
REQ-032 pattern=8'b0000_1011, pat_len=3, repeat_cnt=0, gap=0, start pulse at edge E -> out_stream 1,0,1,1 with out_valid=1 in cycles E+1..E+4, done=1 in E+5, state=0 in E+6.
REQ-033 Same pattern, repeat_cnt=1, gap=2 -> out_stream sequence 1,0,1,1,0,0,1,0,1,1 with out_valid low only in the two gap cycles, a single done pulse after the 10th cycle.
REQ-034 pattern=8'hA5, pat_len=7, repeat_cnt=1, gap=0 -> 16 contiguous valid bits 1010_0101_1010_0101, no bubble.
REQ-035 start re-pulsed at cycles 2 and 4 of a run, and pattern changed mid-run -> output identical to the undisturbed run, with exactly one done pulse.
REQ-036 sync_reset=1 during the 3rd bit of SHIFT and again during GAP -> next cycle state=0, out_valid=0, busy=0, no done pulse; a following start runs normally.
REQ-037 Loop output into the team's sequence detector -> the detector's out asserts exactly at the expected positions for the transmitted stream.
